// File: rtl/clk_lock_seq.sv
// Clock-lock sequencer: drives the DCM/PLL reset, waits for a qualified lock,
// retries a bounded number of times and raises clock_ready once lock is stable.
module clk_lock_seq #(
  parameter int unsigned SYNC_STAGES   = 3,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned RETRY_W       = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               lock_in,
  input  logic               req_relock,
  output logic               dcm_rst,
  output logic               clock_ready,
  output logic               fail,
  output logic               lost_lock,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StReset    = 3'd1,
    StWaitLock = 3'd2,
    StStable   = 3'd3,
    StReady    = 3'd4,
    StFail     = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0]   RstLast     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SyncCnt     = CNT_W'(SYNC_STAGES);
  localparam logic [RETRY_W-1:0] MaxRetries  = RETRY_W'(MAX_RETRIES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 dcm_rst_q, clock_ready_q, fail_q, lost_lock_q;
  logic                 lost_d;
  logic                 relock_take;
  logic                 attempt_failed;
  logic                 reload;

  // Lock synchroniser: free-running and deliberately unreset.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state, retry and counter decisions in priority order.
  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    lost_d         = 1'b0;
    relock_take    = 1'b0;
    attempt_failed = 1'b0;

    if (!enable) begin
      state_d = StIdle;
    end else if (req_relock && (state_q != StIdle)) begin
      state_d     = StReset;
      retry_d     = '0;
      relock_take = 1'b1;
    end else begin
      case (state_q)
        StIdle:  state_d = StReset;
        StReset: if (cnt_q == RstLast) state_d = StWaitLock;
        StWaitLock: begin
          // Early lock_s samples may still carry the previous attempt's lock.
          if ((cnt_q >= SyncCnt) && lock_s) begin
            state_d = StStable;
          end else if (cnt_q == TimeoutLast) begin
            attempt_failed = 1'b1;
          end
        end
        StStable: begin
          if (!lock_s) begin
            attempt_failed = 1'b1;
          end else if (cnt_q == StableLast) begin
            state_d = StReady;
          end
        end
        StReady: begin
          if (!lock_s) begin
            state_d = StReset;
            retry_d = '0;
            lost_d  = 1'b1;
          end
        end
        StFail:  state_d = StFail;
        default: state_d = StIdle;
      endcase

      if (attempt_failed) begin
        retry_d = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
        state_d = (retry_d == MaxRetries) ? StFail : StReset;
      end
    end

    if (state_d == StIdle) begin
      retry_d = '0;
    end

    // Counter restarts on any state entry, including a relock re-entry of RESET.
    reload = (state_d != state_q) || relock_take;
    if (reload) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, counter and outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      retry_q       <= '0;
      dcm_rst_q     <= 1'b1;
      clock_ready_q <= 1'b0;
      fail_q        <= 1'b0;
      lost_lock_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      dcm_rst_q     <= state_d inside {StIdle, StReset, StFail};
      clock_ready_q <= (state_d == StReady);
      fail_q        <= (state_d == StFail);
      lost_lock_q   <= lost_d;
    end
  end

  assign dcm_rst     = dcm_rst_q;
  assign clock_ready = clock_ready_q;
  assign fail        = fail_q;
  assign lost_lock   = lost_lock_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule
